alu_share_arbiter: RTL and testbench

- Shares one 8-bit ALU between NUM_REQ requesters. Each requester presents operands and an opcode, and the block grants access round-robin.
- One operation at a time: operands are latched, the result is computed and registered, then returned with a one-cycle done pulse to the winner.
- Sits between the button/state-machine front ends and the ALU result display. Lets several calculator front ends (local panel, UART console, self-test) use one datapath.

---
 rtl/alu_share_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one registered ALU between NUM_REQ requesters.
// Optional status flags (carry/borrow, zero) are enabled with `define ALU_SHARE_FLAGS_EN.
module alu_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int OP_W    = 3
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] op_a,
   input  logic [NUM_REQ*DATA_W-1:0] op_b,
   input  logic [NUM_REQ*OP_W-1:0]   opcode,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         result,
   output logic                      busy
`ifdef ALU_SHARE_FLAGS_EN
   ,
   output logic [1:0]                flags
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W-1:0]   LAST = PTR_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t              state, state_next;
   logic [PTR_W-1:0]    rr_ptr, rr_next;
   logic [PTR_W-1:0]    owner, owner_next;
   logic [DATA_W-1:0]   lat_a, lat_b, a_next, b_next;
   logic [OP_W-1:0]     lat_op, op_next;
   logic [NUM_REQ-1:0]  grant_next, done_next;
   logic [DATA_W-1:0]   result_next, alu_res;

   logic [PTR_W-1:0]    pick, pick_hi, pick_lo;
   logic                found_hi, found_lo;
   logic [DATA_W-1:0]   a_sel, b_sel;
   logic [OP_W-1:0]     op_sel;

   // Round-robin: first requester at or above rr_ptr, else the lowest one below it.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      pick_hi  = '0;
      pick_lo  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found_hi && req[j] && (PTR_W'(j) >= rr_ptr)) begin
            found_hi = 1'b1;
            pick_hi  = PTR_W'(j);
         end
         if (!found_lo && req[j]) begin
            found_lo = 1'b1;
            pick_lo  = PTR_W'(j);
         end
      end
      pick = found_hi ? pick_hi : pick_lo;
   end

   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      op_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick == PTR_W'(i)) begin
            a_sel  = op_a[i*DATA_W +: DATA_W];
            b_sel  = op_b[i*DATA_W +: DATA_W];
            op_sel = opcode[i*OP_W +: OP_W];
         end
      end
   end

   always_comb begin
      unique case (lat_op)
         OP_W'(0): alu_res = lat_a ^ lat_b;
         OP_W'(1): alu_res = lat_a & lat_b;
         OP_W'(2): alu_res = lat_a | lat_b;
         OP_W'(3): alu_res = lat_a + lat_b;
         OP_W'(4): alu_res = lat_a - lat_b;
         default:  alu_res = '0;
      endcase
   end

`ifdef ALU_SHARE_FLAGS_EN
   logic [1:0] flags_next;
   logic       carry;

   // A wrapped sum smaller than an addend means the add carried out.
   always_comb begin
      carry = 1'b0;
      if (lat_op == OP_W'(3))      carry = (alu_res < lat_a);
      else if (lat_op == OP_W'(4)) carry = (lat_a < lat_b);
   end
`endif

   // NOTE: every next-value gets a hold default first so no latch can be inferred.
   always_comb begin
      state_next  = state;
      rr_next     = rr_ptr;
      owner_next  = owner;
      a_next      = lat_a;
      b_next      = lat_b;
      op_next     = lat_op;
      grant_next  = grant;
      done_next   = done;
      result_next = result;
`ifdef ALU_SHARE_FLAGS_EN
      flags_next  = flags;
`endif
      case (state)
         S_IDLE: begin
            if (found_lo) begin
               owner_next = pick;
               a_next     = a_sel;
               b_next     = b_sel;
               op_next    = op_sel;
               grant_next = ONE << pick;
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            result_next = alu_res;
`ifdef ALU_SHARE_FLAGS_EN
            flags_next  = {(alu_res == '0), carry};
`endif
            done_next   = ONE << owner;
            state_next  = S_DONE;
         end
         S_DONE: begin
            grant_next = '0;
            done_next  = '0;
            rr_next    = (owner == LAST) ? '0 : owner + 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         grant  <= '0;
         done   <= '0;
         result <= '0;
         // NOTE: operand latches are reset too, so a restarted block never exposes stale operands.
         lat_a  <= '0;
         lat_b  <= '0;
         lat_op <= '0;
`ifdef ALU_SHARE_FLAGS_EN
         flags  <= '0;
`endif
      end else begin
         state  <= state_next;
         rr_ptr <= rr_next;
         owner  <= owner_next;
         grant  <= grant_next;
         done   <= done_next;
         result <= result_next;
         lat_a  <= a_next;
         lat_b  <= b_next;
         lat_op <= op_next;
`ifdef ALU_SHARE_FLAGS_EN
         flags  <= flags_next;
`endif
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
// Bench for alu_share_arbiter: transaction-level reference model compared every cycle,
// directed scenarios pinned with literal results, then randomized request traffic.
module tb_alu_share_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int OW = 3;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic [N-1:0]  req     = '0;
   logic [N*DW-1:0] op_a  = '0;
   logic [N*DW-1:0] op_b  = '0;
   logic [N*OW-1:0] opcode = '0;
   logic [N-1:0]  grant, done;
   logic [DW-1:0] result;
   logic          busy;
`ifdef ALU_SHARE_FLAGS_EN
   logic [1:0]    flags;
`endif

   alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .op_a(op_a), .op_b(op_b),
      .opcode(opcode), .grant(grant), .done(done), .result(result), .busy(busy)
`ifdef ALU_SHARE_FLAGS_EN
      , .flags(flags)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      case (op)
         3'd0: return a ^ b;
         3'd1: return a & b;
         3'd2: return a | b;
         3'd3: return 8'((int'(a) + int'(b)) % 256);
         3'd4: return 8'((int'(a) - int'(b) + 256) % 256);
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [1:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      logic c;
      c = 1'b0;
      if (op == 3'd3) c = (int'(a) + int'(b)) > 255;
      if (op == 3'd4) c = int'(a) < int'(b);
      return {ref_alu(a, b, op) == 8'h00, c};
   endfunction

   function automatic int ref_pick(input logic [N-1:0] r, input int rr);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (rr + k) % N;
         if ((r & (N'(1) << idx)) != '0) return idx;
      end
      return -1;
   endfunction

   function automatic logic [7:0] field_d(input logic [N*DW-1:0] bus, input int i);
      return DW'(bus >> (i*DW));
   endfunction

   function automatic logic [2:0] field_o(input logic [N*OW-1:0] bus, input int i);
      return OW'(bus >> (i*OW));
   endfunction

   typedef struct { int idx; logic [7:0] res; logic [1:0] fl; } done_t;
   typedef struct { int idx; int cyc; } grant_t;
   done_t  done_q[$];
   grant_t grant_q[$];

   int         m_owner, m_age, m_rr, m_cyc, m_pick;
   int         m_wait [N];
   logic [7:0] m_a, m_b, m_res;
   logic [2:0] m_op;
   logic [1:0] m_fl;
   logic [N-1:0] exp_grant, exp_done;

   always_comb m_pick = ref_pick(req, m_rr);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_owner <= -1; m_age <= 0; m_rr <= 0; m_cyc <= 0;
         m_a <= '0; m_b <= '0; m_op <= '0; m_res <= '0; m_fl <= '0;
         for (int i = 0; i < N; i++) m_wait[i] <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
         for (int i = 0; i < N; i++) if (!req[i]) m_wait[i] <= 0;
         if (m_owner >= 0) begin
            if (m_age == 0) begin
               m_age <= 1;
               m_res <= ref_alu(m_a, m_b, m_op);
               m_fl  <= ref_flags(m_a, m_b, m_op);
               done_q.push_back('{m_owner, ref_alu(m_a, m_b, m_op), ref_flags(m_a, m_b, m_op)});
            end else begin
               m_owner <= -1;
               m_age   <= 0;
               m_rr    <= (m_owner + 1) % N;
            end
         end else if (m_pick >= 0) begin
            check("wait_bound", 32'(m_wait[m_pick] <= N-1), 32'd1);
            for (int i = 0; i < N; i++) begin
               if (i == m_pick) m_wait[i] <= 0;
               else if (req[i]) m_wait[i] <= m_wait[i] + 1;
            end
            m_owner <= m_pick;
            m_age   <= 0;
            m_a     <= field_d(op_a, m_pick);
            m_b     <= field_d(op_b, m_pick);
            m_op    <= field_o(opcode, m_pick);
            grant_q.push_back('{m_pick, m_cyc});
         end
      end
   end

   always_comb begin
      exp_grant = '0;
      exp_done  = '0;
      if (m_owner >= 0) begin
         exp_grant = N'(1) << m_owner;
         if (m_age == 1) exp_done = exp_grant;
      end
   end

   // Cycle-by-cycle comparison, sampled on the inactive edge.
   always @(negedge clk) begin
      check("grant",  32'(grant),  32'(exp_grant));
      check("done",   32'(done),   32'(exp_done));
      check("result", 32'(result), 32'(m_res));
      check("busy",   32'(busy),   32'(m_owner >= 0));
`ifdef ALU_SHARE_FLAGS_EN
      check("flags",  32'(flags),  32'(m_fl));
`endif
   end

   // ---------------- stimulus helpers ----------------
   logic [N-1:0] hold = '0;

   // Requesters drop req on their done pulse unless told to keep requesting.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < N; i++)
         if (m_owner == i && m_age == 1 && !hold[i]) req[i] = 1'b0;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
      op_a[i*DW +: DW]   = a;
      op_b[i*DW +: DW]   = b;
      opcode[i*OW +: OW] = o;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      hold    = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic wait_done(input int target, input int budget);
      int k;
      k = 0;
      while (done_q.size() < target && k < budget) begin
         tick();
         k++;
      end
      check("timeout_done", 32'(done_q.size() >= target), 32'd1);
      tick();
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((req != '0 || m_owner >= 0) && k < budget) begin
         tick();
         k++;
      end
      check("timeout_idle", 32'(req == '0 && m_owner < 0), 32'd1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int base, g0;
      logic [7:0] exp_res [4];
      logic [1:0] exp_fl  [4];
      int         exp_gi  [4];

      do_reset();
      check("reset_grant",  32'(grant),  32'h0);
      check("reset_result", 32'(result), 32'h0);
      check("reset_busy",   32'(busy),   32'h0);

      // Single request: 0x0F ^ 0x33
      base = done_q.size();
      set_op(0, 8'h0F, 8'h33, 3'd0);
      req = 4'b0001;
      wait_done(base + 1, 10);
      check("t1_idx",    32'(done_q[base].idx), 32'd0);
      check("t1_res",    32'(done_q[base].res), 32'h3C);
      check("t1_result", 32'(result), 32'h3C);
      check("t1_busy",   32'(busy), 32'h0);

      // Four simultaneous requests served 0,1,2,3
      do_reset();
      base = done_q.size();
      set_op(0, 8'hF0, 8'h3C, 3'd1);
      set_op(1, 8'h0F, 8'h30, 3'd2);
      set_op(2, 8'hFF, 8'h02, 3'd3);
      set_op(3, 8'h05, 8'h07, 3'd4);
      req = 4'b1111;
      wait_done(base + 4, 40);
      exp_res = '{8'h30, 8'h3F, 8'h01, 8'hFE};
      exp_fl  = '{2'b00, 2'b00, 2'b01, 2'b01};
      for (int k = 0; k < 4; k++) begin
         check("t2_idx", 32'(done_q[base+k].idx), 32'(k));
         check("t2_res", 32'(done_q[base+k].res), 32'(exp_res[k]));
`ifdef ALU_SHARE_FLAGS_EN
         check("t2_flags", 32'(done_q[base+k].fl), 32'(exp_fl[k]));
`endif
      end
      wait_idle(20);

      // Fairness: r1 keeps requesting, r2 requests once
      do_reset();
      g0 = grant_q.size();
      set_op(1, 8'h11, 8'h22, 3'd2);
      set_op(2, 8'h33, 8'h44, 3'd0);
      hold[1] = 1'b1;
      req = 4'b0110;
      for (int k = 0; k < 40 && grant_q.size() < g0 + 4; k++) tick();
      hold[1] = 1'b0;
      wait_idle(30);
      exp_gi = '{1, 2, 1, 1};
      for (int k = 0; k < 4; k++) check("t3_order", 32'(grant_q[g0+k].idx), 32'(exp_gi[k]));
      check("t3_gap", 32'(grant_q[g0+3].cyc - grant_q[g0+2].cyc >= 3), 32'd1);
      check("t3_gap_exact", 32'(grant_q[g0+3].cyc - grant_q[g0+2].cyc), 32'd3);

      // Operand change one cycle after grant has no effect
      base = done_q.size();
      set_op(0, 8'h10, 8'h01, 3'd3);
      req[0] = 1'b1;
      tick();
      check("t4_grant", 32'(grant), 32'b0001);
      op_a[0 +: DW] = 8'h20;
      wait_done(base + 1, 10);
      check("t4_res",    32'(done_q[base].res), 32'h11);
      check("t4_result", 32'(result), 32'h11);

      // Invalid opcode yields zero, done still pulses
      base = done_q.size();
      set_op(1, 8'h5A, 8'h33, 3'd6);
      req[1] = 1'b1;
      wait_done(base + 1, 10);
      check("t5_idx",    32'(done_q[base].idx), 32'd1);
      check("t5_res",    32'(done_q[base].res), 32'h00);
      check("t5_result", 32'(result), 32'h00);
`ifdef ALU_SHARE_FLAGS_EN
      check("t5_flags",  32'(done_q[base].fl), 32'b10);
`endif

      // Reset in the middle of an operation
      base = done_q.size();
      set_op(3, 8'hAA, 8'h55, 3'd2);
      req[3] = 1'b1;
      wait_done(base + 1, 10);
      check("t6_pre_result", 32'(result), 32'hFF);
      set_op(0, 8'h01, 8'h02, 3'd3);
      set_op(2, 8'h07, 8'h03, 3'd4);
      req = 4'b0001;
      tick();
      check("t6_exec_busy", 32'(busy), 32'd1);
      req = 4'b0100;
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_grant",  32'(grant),  32'h0);
      check("t6_rst_done",   32'(done),   32'h0);
      check("t6_rst_result", 32'(result), 32'h0);
      check("t6_rst_busy",   32'(busy),   32'h0);
      base = done_q.size();
      tick();
      tick();
      reset_n = 1'b1;
      wait_done(base + 1, 10);
      check("t6_first_idx", 32'(done_q[base].idx), 32'd2);
      check("t6_first_res", 32'(done_q[base].res), 32'h04);
      wait_idle(20);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(3) == 0) begin
               set_op(i, 8'($urandom), 8'($urandom), 3'($urandom_range(7)));
               req[i] = 1'b1;
            end else if (req[i] && m_owner == i) begin
               if ($urandom_range(7) == 0) op_a[i*DW +: DW] = 8'($urandom);
               if ($urandom_range(15) == 0) req[i] = 1'b0;
            end
         end
      end
      wait_idle(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
